neighbor_counter: RTL and testbench
===================================

// Module: neighbor_counter
// PURPOSE
//  Minesweeper board stage directly downstream of the random bomb placer.
//  Captures the placed 8x8 bomb map and scans it once, one cell per clock.
//  Produces each cell's adjacent-bomb count (0..8) and the total bomb count.
//  The display/reveal logic consumes these results.
// PARAMETERS
//  ROWS   8  board rows
//  COLS   8  board columns
//  CNT_W  4  width of each per-cell neighbour count (must hold 8)
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst         in   1                 synchronous, active-high reset
//  start       in   1                 request a scan; sampled only in IDLE
//  bomb_map    in   [ROWS-1:0][COLS-1:0]        1 = bomb at [r][c]
//  busy        out  1                 high while state = SCAN
//  done        out  1                 one-cycle pulse when scan completes
//  valid       out  1                 count_map/bomb_total hold a complete result
//  count_map   out  [ROWS-1:0][COLS-1:0][CNT_W-1:0]  adjacent bombs per cell
//  bomb_total  out  7                 number of 1s in the captured map (0..64)
// BEHAVIOUR
//  Reset (sync, rst=1 at a rising edge):
//   - state=IDLE, busy=0, done=0, valid=0, count_map=0, bomb_total=0, idx=0.
//   - Reset wins over any other event, including mid-SCAN.
//  Registers: captured map cap_map, 6-bit cell index idx (row-major, r=idx/COLS, c=idx%COLS).
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   - IDLE: start=1 -> cap_map<=bomb_map, idx<=0, count_map<=0, bomb_total<=0,
//     valid<=0, go SCAN. start=0 -> hold; outputs keep their last values.
//   - SCAN: each cycle, count_map[r][c] <= popcount of the 8 neighbours
//     (r-1..r+1, c-1..c+1, excluding self) in cap_map.
//     bomb_total += cap_map[r][c]. idx++.
//     When idx = ROWS*COLS-1, go DONE.
//   - DONE: done=1 and valid<=1 for exactly one cycle, then IDLE.
//  Latency:
//   - Start sampled at edge E0; SCAN occupies the next 64 cycles.
//   - done is high in cycle 65 after E0; valid is high from that cycle on.
//  Boundaries:
//   - No wrap-around. Out-of-range neighbours count as 0.
//     Corners see 3 neighbours, edges 5, interior 8.
//   - A bomb cell still gets its neighbour count; its own bit is never included.
//   - start in SCAN or DONE is ignored; start held high re-triggers only from IDLE.
//   - bomb_map changes after capture have no effect on the scan in progress.
//   - valid stays 1 until the next accepted start or reset.
//  Arithmetic:
//   - Counts are unsigned, max 8 (fits CNT_W=4).
//   - bomb_total is unsigned 7-bit, max 64; no saturation needed.
// TESTING
//  1. All-zero map, start 1 cycle -> busy 64 cycles; done at cycle 65;
//     all counts 0; bomb_total=0; valid=1.
//  2. Single bomb at [0][0] -> [0][1]=[1][0]=[1][1]=1, all other counts 0
//     (incl. [0][0]); bomb_total=1.
//  3. Single bomb at [3][4] -> its 8 neighbours =1, [3][4]=0, all others 0;
//     bomb_total=1.
//  4. All-ones map -> corners 3, non-corner edges 5, interior 8; bomb_total=64.
//  5. Assert rst when idx=20 -> next cycle busy=0, valid=0, count_map=0,
//     bomb_total=0; no done pulse.
//  6. Start pulses during SCAN are ignored; change bomb_map mid-scan -> result
//     matches the captured map. Second start after done -> valid drops to 0 and
//     rescan yields the new map's counts.

Source files
------------

// File: rtl/neighbor_counter.sv
// Minesweeper neighbour counter: captures an 8x8 bomb map on start and scans it one cell per clock,
// producing per-cell adjacent-bomb counts and the total bomb count (64 scan cycles, done in cycle 65).
module neighbor_counter #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [ROWS-1:0][COLS-1:0]             bomb_map,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  valid,
  output logic [ROWS-1:0][COLS-1:0][CNT_W-1:0]  count_map,
  output logic [6:0]                            bomb_total
);

  localparam int IDX_W = 6;
  localparam int RS    = $clog2(ROWS);
  localparam int CS    = $clog2(COLS);
  localparam int PRW   = $clog2(ROWS + 2);
  localparam int PCW   = $clog2(COLS + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS * COLS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t                                state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]             cap_map_q, cap_map_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [ROWS-1:0][COLS-1:0][CNT_W-1:0]  count_map_q, count_map_d;
  logic [6:0]                            bomb_total_q, bomb_total_d;
  logic                                  valid_q, valid_d;

  // Zero border around the captured map so the 3x3 window never needs bounds checks.
  logic [ROWS+1:0][COLS+1:0] pad_map;

  for (genvar r = 0; r < ROWS + 2; r++) begin : g_pr
    for (genvar c = 0; c < COLS + 2; c++) begin : g_pc
      if (r == 0 || r == ROWS + 1 || c == 0 || c == COLS + 1) begin : g_edge
        assign pad_map[r][c] = 1'b0;
      end else begin : g_in
        assign pad_map[r][c] = cap_map_q[r-1][c-1];
      end
    end
  end

  logic [RS-1:0]    row;
  logic [CS-1:0]    col;
  logic [PRW-1:0]   pr0, pr1, pr2;
  logic [PCW-1:0]   pc0, pc1, pc2;
  logic [CNT_W-1:0] nbr_cnt;

  always_comb begin
    row = RS'(idx_q / IDX_W'(COLS));
    col = CS'(idx_q % IDX_W'(COLS));
    pr0 = PRW'(row);
    pr1 = pr0 + PRW'(1);
    pr2 = pr0 + PRW'(2);
    pc0 = PCW'(col);
    pc1 = pc0 + PCW'(1);
    pc2 = pc0 + PCW'(2);
    // Centre (pr1, pc1) is the cell itself and is left out.
    nbr_cnt = CNT_W'(pad_map[pr0][pc0]) + CNT_W'(pad_map[pr0][pc1]) + CNT_W'(pad_map[pr0][pc2])
            + CNT_W'(pad_map[pr1][pc0])                               + CNT_W'(pad_map[pr1][pc2])
            + CNT_W'(pad_map[pr2][pc0]) + CNT_W'(pad_map[pr2][pc1]) + CNT_W'(pad_map[pr2][pc2]);
  end

  always_comb begin
    state_d      = state_q;
    cap_map_d    = cap_map_q;
    idx_d        = idx_q;
    count_map_d  = count_map_q;
    bomb_total_d = bomb_total_q;
    valid_d      = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_map_d    = bomb_map;
          idx_d        = '0;
          count_map_d  = '0;
          bomb_total_d = '0;
          valid_d      = 1'b0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        count_map_d[row][col] = nbr_cnt;
        bomb_total_d          = bomb_total_q + 7'(cap_map_q[row][col]);
        idx_d                 = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // Raise valid on entry to DONE so it is visible alongside the done pulse.
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cap_map_q    <= '0;
      idx_q        <= '0;
      count_map_q  <= '0;
      bomb_total_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_map_q    <= cap_map_d;
      idx_q        <= idx_d;
      count_map_q  <= count_map_d;
      bomb_total_q <= bomb_total_d;
      valid_q      <= valid_d;
    end
  end

  assign busy       = (state_q == ST_SCAN);
  assign done       = (state_q == ST_DONE);
  assign valid      = valid_q;
  assign count_map  = count_map_q;
  assign bomb_total = bomb_total_q;

endmodule

// File: tb/tb_neighbor_counter.sv
// Self-checking bench for neighbor_counter: directed and random maps against a plain-arithmetic board model.
module tb_neighbor_counter;

  typedef logic [7:0][7:0] map_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  map_t                 bomb_map;
  logic                 busy;
  logic                 done;
  logic                 valid;
  logic [7:0][7:0][3:0] count_map;
  logic [6:0]           bomb_total;

  int tests  = 0;
  int failed = 0;

  neighbor_counter #(.ROWS(8), .COLS(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bomb_map   (bomb_map),
    .busy       (busy),
    .done       (done),
    .valid      (valid),
    .count_map  (count_map),
    .bomb_total (bomb_total)
  );

  always #5 clk = ~clk;

  // Reference: count bombs in the in-bounds 3x3 neighbourhood, excluding the cell itself.
  function automatic int exp_cnt(input map_t m, input int r, input int c);
    int n;
    n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
          n += int'(m[r+dr][c+dc]);
    return n;
  endfunction

  function automatic int exp_total(input map_t m);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(m[i/8][i%8]);
    return n;
  endfunction

  // Pulses start for one edge and follows the scan; done_cyc stays -1 if done never arrives.
  task automatic do_scan(input map_t m, output int busy_n, output int done_cyc, output logic valid_first);
    busy_n   = 0;
    done_cyc = -1;
    @(negedge clk);
    bomb_map = m;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    valid_first = valid;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (busy) busy_n++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bomb_map = '0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0)  begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0)  begin failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (bomb_total !== 7'd0) begin failed++; $display("FAIL reset_total got %0d exp 0", bomb_total); end
    tests++; if (count_map !== '0) begin failed++; $display("FAIL reset_counts got %h exp 0", count_map); end
    rst = 1'b0;
  endtask

  task automatic test_scan(input string name, input map_t m);
    int busy_n, done_cyc, bad, fr, fc, fv, fe;
    logic vf;
    do_scan(m, busy_n, done_cyc, vf);
    tests++; if (done_cyc !== 65) begin failed++; $display("FAIL %s done_cycle got %0d exp 65", name, done_cyc); end
    tests++; if (busy_n !== 64) begin failed++; $display("FAIL %s busy_cycles got %0d exp 64", name, busy_n); end
    tests++; if (vf !== 1'b0) begin failed++; $display("FAIL %s valid_after_start got %b exp 0", name, vf); end
    tests++; if (valid !== 1'b1) begin failed++; $display("FAIL %s valid_at_done got %b exp 1", name, valid); end
    tests++;
    if (bomb_total !== 7'(exp_total(m))) begin
      failed++; $display("FAIL %s bomb_total got %0d exp %0d", name, bomb_total, exp_total(m));
    end
    bad = 0; fr = 0; fc = 0; fv = 0; fe = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (count_map[r][c] !== 4'(exp_cnt(m, r, c))) begin
          if (bad == 0) begin fr = r; fc = c; fv = int'(count_map[r][c]); fe = exp_cnt(m, r, c); end
          bad++;
        end
    tests++;
    if (bad !== 0) begin
      failed++;
      $display("FAIL %s counts %0d cells wrong, first [%0d][%0d] got %0d exp %0d", name, bad, fr, fc, fv, fe);
    end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL %s done_width got %b exp 0 after one cycle", name, done); end
    repeat (3) @(negedge clk);
    tests++; if (valid !== 1'b1) begin failed++; $display("FAIL %s valid_hold got %b exp 1", name, valid); end
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_busy;
    @(negedge clk);
    bomb_map = '1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (busy !== 1'b0)  begin failed++; $display("FAIL midrst_busy got %b exp 0", busy); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL midrst_valid got %b exp 0", valid); end
    tests++; if (bomb_total !== 7'd0) begin failed++; $display("FAIL midrst_total got %0d exp 0", bomb_total); end
    tests++; if (count_map !== '0) begin failed++; $display("FAIL midrst_counts got %h exp 0", count_map); end
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) seen_done++;
      if (busy) seen_busy++;
      @(negedge clk);
    end
    tests++; if (seen_done !== 0) begin failed++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen_done); end
    tests++; if (seen_busy !== 0) begin failed++; $display("FAIL midrst_no_busy got %0d cycles exp 0", seen_busy); end
  endtask

  task automatic test_back_to_back();
    map_t a, b;
    int done_cyc, done2, bad;
    a = map_t'({$urandom(), $urandom()});
    b = ~a;
    done_cyc = -1;
    @(negedge clk);
    bomb_map = a;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 66; cyc++) begin
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        bad = 0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            if (count_map[r][c] !== 4'(exp_cnt(a, r, c))) bad++;
        tests++; if (bad !== 0) begin failed++; $display("FAIL b2b_captured_counts got %0d bad cells exp 0", bad); end
        tests++;
        if (bomb_total !== 7'(exp_total(a))) begin
          failed++; $display("FAIL b2b_captured_total got %0d exp %0d", bomb_total, exp_total(a));
        end
      end
      if (cyc == 10 || cyc == 30 || cyc >= 40) begin start = 1'b1; bomb_map = b; end
      else start = 1'b0;
      @(negedge clk);
    end
    tests++; if (done_cyc !== 65) begin failed++; $display("FAIL b2b_done_cycle got %0d exp 65", done_cyc); end
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL b2b_retrigger_busy got %b exp 1", busy); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL b2b_valid_drop got %b exp 0", valid); end
    start = 1'b0;
    done2 = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (done) begin done2 = cyc; break; end
      @(negedge clk);
    end
    tests++; if (done2 < 0) begin failed++; $display("FAIL b2b_second_done got timeout exp pulse"); end
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (count_map[r][c] !== 4'(exp_cnt(b, r, c))) bad++;
    tests++; if (bad !== 0) begin failed++; $display("FAIL b2b_rescan_counts got %0d bad cells exp 0", bad); end
    tests++;
    if (bomb_total !== 7'(exp_total(b))) begin
      failed++; $display("FAIL b2b_rescan_total got %0d exp %0d", bomb_total, exp_total(b));
    end
  endtask

  initial begin
    map_t m;
    rst = 1'b1; start = 1'b0; bomb_map = '0;
    test_reset();
    test_scan("zero_map", '0);
    m = '0; m[0][0] = 1'b1;
    test_scan("corner_bomb", m);
    m = '0; m[3][4] = 1'b1;
    test_scan("center_bomb", m);
    test_scan("all_ones", '1);
    m = '0; m[7][7] = 1'b1; m[0][7] = 1'b1; m[7][0] = 1'b1;
    test_scan("far_corners", m);
    for (int i = 0; i < 4; i++) begin
      m = map_t'({$urandom(), $urandom()});
      if (i[0]) m = m & map_t'({$urandom(), $urandom()});
      test_scan("random", m);
    end
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
